// File: rtl/apb_master.sv
// APB3 requester: one outstanding command in, one response out,
// with an optional wait-state timeout for hung slaves.
module apb_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_I =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] C_LAST = CW'(LAST_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                r_state, w_state;
  logic                  r_psel, w_psel;
  logic                  r_penable, w_penable;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
  logic                  r_pwrite, w_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata;
  logic                  r_rsp_valid, w_rsp_valid;
  logic                  r_rsp_error, w_rsp_error;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  w_to_hit;

  assign w_to_hit = TO_EN && (r_cnt == C_LAST);

  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_paddr     = r_paddr;
    w_pwrite    = r_pwrite;
    w_pwdata    = r_pwdata;
    w_rsp_valid = 1'b0;
    w_rsp_error = r_rsp_error;
    w_rsp_rdata = r_rsp_rdata;
    w_cnt       = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_paddr   = cmd_addr;
          w_pwrite  = cmd_write;
          if (cmd_write) w_pwdata = cmd_wdata;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_state   = SETUP;
        end
      end
      SETUP: begin
        w_penable = 1'b1;
        w_cnt     = '0;
        w_state   = ACCESS;
      end
      ACCESS: begin
        // Slave completion wins over a timeout on the same edge
        if (pready) begin
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b0;
          w_rsp_rdata = r_pwrite ? '0 : prdata;
          w_state     = IDLE;
        end else if (w_to_hit) begin
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_error = 1'b1;
          w_rsp_rdata = '0;
          w_state     = IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_paddr     <= w_paddr;
      r_pwrite    <= w_pwrite;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_error <= w_rsp_error;
      r_rsp_rdata <= w_rsp_rdata;
      r_cnt       <= w_cnt;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: writes, wait states, timeout,
// back-to-back commands and reset in the middle of a transfer.
module tb_apb_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        psel;
  logic        penable;
  logic [9:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  apb_master #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .psel(psel),
    .penable(penable),
    .paddr(paddr),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .pready(pready),
    .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  int nacc;
  int nrsp;
  int acc_cyc[4];
  logic acc;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    step();
    step();
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_paddr", 32'(paddr), 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    reset = 1'b0;
    step();

    // Zero-wait write; pready high early must be ignored outside ACCESS
    pready    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 10'h3A4;
    cmd_wdata = 32'hDEADBEEF;
    step();
    cmd_valid = 1'b0;
    check("wr_setup_psel", 32'(psel), 1);
    check("wr_setup_pen", 32'(penable), 0);
    check("wr_setup_rdy", 32'(cmd_ready), 0);
    check("wr_setup_paddr", 32'(paddr), 32'h3A4);
    check("wr_setup_pwrite", 32'(pwrite), 1);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    step();
    check("wr_acc_psel", 32'(psel), 1);
    check("wr_acc_pen", 32'(penable), 1);
    check("wr_acc_paddr", 32'(paddr), 32'h3A4);
    check("wr_acc_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_acc_rsp", 32'(rsp_valid), 0);
    step();
    check("wr_rsp_valid", 32'(rsp_valid), 1);
    check("wr_rsp_err", 32'(rsp_error), 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_done_psel", 32'(psel), 0);
    check("wr_done_pen", 32'(penable), 0);
    check("wr_done_rdy", 32'(cmd_ready), 1);
    check("wr_hold_paddr", 32'(paddr), 32'h3A4);
    step();
    check("wr_rsp_pulse", 32'(rsp_valid), 0);

    // Read with three wait states
    pready    = 1'b0;
    prdata    = 32'h12345678;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h010;
    cmd_wdata = 32'h0BAD0BAD;
    step();
    cmd_valid = 1'b0;
    check("rd_paddr", 32'(paddr), 32'h010);
    check("rd_pwrite", 32'(pwrite), 0);
    check("rd_pwdata_kept", pwdata, 32'hDEADBEEF);
    step();
    check("rd_acc_pen", 32'(penable), 1);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (psel && penable) n++;
      check("rd_wait_rsp", 32'(rsp_valid), 0);
    end
    pready = 1'b1;
    step();
    check("rd_access_len", n, 4);
    check("rd_rsp_valid", 32'(rsp_valid), 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd_rsp_err", 32'(rsp_error), 0);
    pready = 1'b0;
    step();

    // Stuck slave: ACCESS must last exactly 16 cycles
    prdata    = 32'hCAFEF00D;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h155;
    step();
    cmd_valid = 1'b0;
    step();
    n = 0;
    while (psel && penable && n < 40) begin
      n++;
      step();
    end
    check("to_access_len", n, 16);
    check("to_rsp_valid", 32'(rsp_valid), 1);
    check("to_rsp_err", 32'(rsp_error), 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", 32'(psel), 0);
    check("to_rdy", 32'(cmd_ready), 1);
    step();
    check("to_err_hold", 32'(rsp_error), 1);

    // pready on the 16th ACCESS cycle is a success
    prdata    = 32'hA5A5A5A5;
    cmd_valid = 1'b1;
    cmd_addr  = 10'h2AA;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    check("last_still_acc", 32'(penable), 1);
    pready = 1'b1;
    step();
    check("last_rsp_valid", 32'(rsp_valid), 1);
    check("last_rsp_err", 32'(rsp_error), 0);
    check("last_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
    step();

    // Four back-to-back reads with cmd_valid held high
    pready    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h100;
    prdata    = '0;
    nacc = 0;
    nrsp = 0;
    for (int c = 0; c < 30 && nrsp < 4; c++) begin
      acc = cmd_ready && cmd_valid;
      step();
      if (acc) begin
        acc_cyc[nacc] = c;
        check("b2b_paddr", 32'(paddr), 32'h100 + nacc);
        prdata = 32'hB0000100 + nacc;
        nacc++;
        if (nacc < 4) cmd_addr = 10'(10'h100 + nacc);
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        check("b2b_rdata", rsp_rdata, 32'hB0000100 + nrsp);
        nrsp++;
      end
    end
    check("b2b_nacc", nacc, 4);
    check("b2b_nrsp", nrsp, 4);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);
    check("b2b_gap3", acc_cyc[3] - acc_cyc[2], 3);
    step();

    // Reset in the middle of ACCESS
    pready    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 10'h0F0;
    cmd_wdata = 32'h11112222;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("mid_in_access", 32'(penable), 1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_psel", 32'(psel), 0);
    check("mid_rst_pen", 32'(penable), 0);
    check("mid_rst_rsp", 32'(rsp_valid), 0);
    check("mid_rst_paddr", 32'(paddr), 0);
    step();
    reset  = 1'b0;
    pready = 1'b1;
    step();
    check("post_rst_rdy", 32'(cmd_ready), 1);
    check("post_rst_norsp", 32'(rsp_valid), 0);
    cmd_valid = 1'b1;
    cmd_addr  = 10'h0F4;
    cmd_wdata = 32'h33334444;
    step();
    cmd_valid = 1'b0;
    check("post_rst_pwdata", pwdata, 32'h33334444);
    step();
    step();
    check("post_rst_rsp", 32'(rsp_valid), 1);
    check("post_rst_err", 32'(rsp_error), 0);
    check("post_rst_rdata", rsp_rdata, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
